// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: FSM states, owner ids and counter width.
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_M0   = 2'd1,
        OWN_M1   = 2'd2
    } owner_t;

    localparam int unsigned CNT_W = 8;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Per-master request/ack bus into the data-memory arbiter.
interface dmem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          req;
    logic          wr;
    logic          lock;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          ack;
    logic [DW-1:0] rdata;

    modport master (output req, wr, lock, addr, wdata, input ack, rdata);
    modport slave  (input req, wr, lock, addr, wdata, output ack, rdata);
endinterface

// File: rtl/dmem_arbiter_satcnt.sv
// 8-bit saturating counter: counts up to limit, clr has priority over inc.
module dmem_arb_satcnt
    import dmem_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             inc,
    input  logic             clr,
    input  logic [CNT_W-1:0] limit,
    output logic             at_limit
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (clr)
            count <= '0;
        else if (inc && (count < limit))
            count <= count + CNT_W'(1);
    end

    assign at_limit = (count >= limit);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the single-port data memory: m0 priority, m1 starvation escalation, bounded lock.
// Optional perf counters enabled by defining ARB_PERF_EN.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int          AW           = 32,
    parameter int          DW           = 32,
    parameter int unsigned STARVE_LIMIT = 8,
    parameter int unsigned LOCK_MAX     = 16
) (
    input  logic           clk,
    input  logic           reset,
    dmem_arbiter_if.slave  m0,
    dmem_arbiter_if.slave  m1,
    output logic           mem_wr,
    output logic           mem_re,
    output logic [AW-1:0]  mem_addr,
    output logic [DW-1:0]  mem_wdata,
    input  logic [DW-1:0]  mem_rdata,
    output logic [31:0]    perf_m0_stall,
    output logic [31:0]    perf_m1_stall,
    output logic [31:0]    perf_conflict
);

    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_LIMIT);
    // lock counter limit is one below LOCK_MAX so at_limit flags the LOCK_MAX-th grant itself
    localparam logic [CNT_W-1:0] LOCK_LIM   = CNT_W'(LOCK_MAX - 1);

    arb_state_t state;
    owner_t     owner;
    logic       grant0, grant1, sel_wr, lock_take;
    logic       starved, lock_last;

    always_comb begin
        owner = OWN_NONE;
        if (!reset) begin
            unique case (state)
                IDLE: begin
                    if (m1.req && (!m0.req || starved))
                        owner = OWN_M1;
                    else if (m0.req)
                        owner = OWN_M0;
                end
                OWN0:    if (m0.req) owner = OWN_M0;
                OWN1:    if (m1.req) owner = OWN_M1;
                default: owner = OWN_NONE;
            endcase
        end
    end

    assign grant0    = (owner == OWN_M0);
    assign grant1    = (owner == OWN_M1);
    assign sel_wr    = grant1 ? m1.wr : m0.wr;
    assign lock_take = (grant0 && m0.lock) || (grant1 && m1.lock);

    assign mem_addr  = grant1 ? m1.addr  : m0.addr;
    assign mem_wdata = grant1 ? m1.wdata : m0.wdata;
    assign mem_wr    = (grant0 || grant1) && sel_wr;
    assign mem_re    = (grant0 || grant1) && !sel_wr;

    assign m0.ack    = grant0;
    assign m1.ack    = grant1;
    assign m0.rdata  = (grant0 && !m0.wr) ? mem_rdata : '0;
    assign m1.rdata  = (grant1 && !m1.wr) ? mem_rdata : '0;

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else begin
            unique case (owner)
                OWN_M0:  state <= (m0.lock && !lock_last) ? OWN0 : IDLE;
                OWN_M1:  state <= (m1.lock && !lock_last) ? OWN1 : IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    dmem_arb_satcnt u_wait1 (
        .clk      (clk),
        .inc      (m1.req && !grant1),
        .clr      (reset || !m1.req || grant1),
        .limit    (STARVE_LIM),
        .at_limit (starved)
    );

    dmem_arb_satcnt u_lock_cnt (
        .clk      (clk),
        .inc      (lock_take),
        .clr      (reset || !lock_take || lock_last),
        .limit    (LOCK_LIM),
        .at_limit (lock_last)
    );

`ifdef ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_m0_stall <= '0;
            perf_m1_stall <= '0;
            perf_conflict <= '0;
        end else begin
            if (m0.req && !grant0) perf_m0_stall <= perf_m0_stall + 32'd1;
            if (m1.req && !grant1) perf_m1_stall <= perf_m1_stall + 32'd1;
            if (m0.req && m1.req)  perf_conflict <= perf_conflict + 32'd1;
        end
    end
`else
    assign perf_m0_stall = '0;
    assign perf_m1_stall = '0;
    assign perf_conflict = '0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: per-cycle expectations queued at drive time, checked at negedge.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_wr, mem_re;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [31:0] perf_m0_stall, perf_m1_stall, perf_conflict;
    logic [31:0] mem [0:511] = '{default: '0};

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       tag;
        logic        ack0, ack1, wr, re, chk_addr;
        logic [31:0] rd0, rd1, addr;
    } exp_t;

    exp_t sb[$];

    localparam logic [31:0] K0 = 32'h2b7e1516, K1 = 32'h28aed2a6,
                            K2 = 32'habf71588, K3 = 32'h09cf4f3c;
    logic [31:0] key [0:3];

    always #5 clk = ~clk;

    dmem_arbiter_if #(.AW(32), .DW(32)) m0_bus ();
    dmem_arbiter_if #(.AW(32), .DW(32)) m1_bus ();

    dmem_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(8), .LOCK_MAX(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .m0            (m0_bus),
        .m1            (m1_bus),
        .mem_wr        (mem_wr),
        .mem_re        (mem_re),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .perf_m0_stall (perf_m0_stall),
        .perf_m1_stall (perf_m1_stall),
        .perf_conflict (perf_conflict)
    );

    assign mem_rdata = mem[mem_addr[10:2]];
    always @(posedge clk) if (mem_wr) mem[mem_addr[10:2]] <= mem_wdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({e.tag, "/ack0"},   32'(m0_bus.ack),   32'(e.ack0));
            check({e.tag, "/ack1"},   32'(m1_bus.ack),   32'(e.ack1));
            check({e.tag, "/rdata0"}, m0_bus.rdata,      e.rd0);
            check({e.tag, "/rdata1"}, m1_bus.rdata,      e.rd1);
            check({e.tag, "/mem_wr"}, 32'(mem_wr),       32'(e.wr));
            check({e.tag, "/mem_re"}, 32'(mem_re),       32'(e.re));
            if (e.chk_addr) check({e.tag, "/mem_addr"}, mem_addr, e.addr);
        end
    end

    task automatic cyc(input string tag, input logic rst,
                       input logic r0, w0, l0, input logic [31:0] a0, d0,
                       input logic r1, w1, l1, input logic [31:0] a1, d1,
                       input logic e0, e1, input logic [31:0] erd0, erd1);
        exp_t e;
        @(posedge clk);
        #1;
        reset        = rst;
        m0_bus.req   = r0; m0_bus.wr = w0; m0_bus.lock = l0; m0_bus.addr = a0; m0_bus.wdata = d0;
        m1_bus.req   = r1; m1_bus.wr = w1; m1_bus.lock = l1; m1_bus.addr = a1; m1_bus.wdata = d1;
        e.tag      = tag;
        e.ack0     = e0;
        e.ack1     = e1;
        e.rd0      = erd0;
        e.rd1      = erd1;
        e.wr       = (e0 && w0) || (e1 && w1);
        e.re       = (e0 && !w0) || (e1 && !w1);
        e.chk_addr = e0 || e1;
        e.addr     = e1 ? a1 : a0;
        sb.push_back(e);
    endtask

    task automatic idle(input string tag);
        cyc(tag, 1'b0, 0, 0, 0, '0, '0, 0, 0, 0, '0, '0, 0, 0, '0, '0);
    endtask

    initial begin
        logic e1;
        key[0] = K0; key[1] = K1; key[2] = K2; key[3] = K3;
        reset = 1'b1;
        m0_bus.req = 0; m0_bus.wr = 0; m0_bus.lock = 0; m0_bus.addr = '0; m0_bus.wdata = '0;
        m1_bus.req = 0; m1_bus.wr = 0; m1_bus.lock = 0; m1_bus.addr = '0; m1_bus.wdata = '0;

        // reset held with a pending m0 write: nothing may commit
        cyc("rst_a", 1, 1, 1, 0, 32'h10, 32'hdeadbeef, 0, 0, 0, '0, '0, 0, 0, '0, '0);
        cyc("rst_b", 1, 1, 1, 0, 32'h10, 32'hdeadbeef, 0, 0, 0, '0, '0, 0, 0, '0, '0);
        idle("post_rst");
        #2;
        check("mem_unchanged", mem[4], 32'h0);
        check("perf_m0_rst", perf_m0_stall, 32'd0);
        check("perf_m1_rst", perf_m1_stall, 32'd0);
        check("perf_cf_rst", perf_conflict, 32'd0);

        cyc("t2_wr", 0, 1, 1, 0, 32'h10, K0, 0, 0, 0, '0, '0, 1, 0, '0, '0);
        cyc("t2_rd", 0, 1, 0, 0, 32'h10, '0, 0, 0, 0, '0, '0, 1, 0, K0, '0);

        for (int k = 0; k < 4; k++)
            cyc($sformatf("pre_%0d", k), 0, 0, 0, 0, '0, '0,
                1, 1, 0, 32'h200 + 32'(4 * k), key[k], 0, 1, '0, '0);
        idle("t3_pre");

        // continuous conflict: m1 escalates after 8 waits
        for (int i = 0; i < 18; i++) begin
            e1 = (i == 8) || (i == 17);
            cyc($sformatf("t3_%0d", i), 0, 1, 0, 0, 32'h10, '0, 1, 0, 0, 32'h10, '0,
                !e1, e1, e1 ? 32'h0 : K0, e1 ? K0 : 32'h0);
        end
        idle("t3_idle");
        #2;
`ifdef ARB_PERF_EN
        check("perf_conflict", perf_conflict, 32'd18);
        check("perf_m1_stall", perf_m1_stall, 32'd16);
        check("perf_m0_stall", perf_m0_stall, 32'd2);
`else
        check("perf_conflict", perf_conflict, 32'd0);
        check("perf_m1_stall", perf_m1_stall, 32'd0);
        check("perf_m0_stall", perf_m0_stall, 32'd0);
`endif

        // m1 locked burst of 4 reads while m0 keeps requesting
        for (int i = 0; i < 13; i++) begin
            int w;
            w  = (i >= 8 && i < 12) ? i - 8 : 0;
            e1 = (i >= 8) && (i < 12);
            cyc($sformatf("t4_%0d", i), 0, 1, 0, 0, 32'h10, '0,
                i < 12, 0, i < 11, 32'h200 + 32'(4 * w), '0,
                !e1, e1, e1 ? 32'h0 : K0, e1 ? key[w] : 32'h0);
        end
        idle("t4_idle");

        // m0 lock forever: forced release after 16 grants, starved m1 then wins
        for (int i = 0; i < 18; i++) begin
            e1 = (i == 16);
            cyc($sformatf("t5_%0d", i), 0, 1, 0, 1, 32'h10, '0,
                i < 17, 0, 0, 32'h204, '0,
                !e1, e1, e1 ? 32'h0 : K0, e1 ? K1 : 32'h0);
        end
        // reset mid-lock drops the locked write
        cyc("t5_rst", 1, 1, 1, 1, 32'h10, 32'hffffffff, 0, 0, 0, '0, '0, 0, 0, '0, '0);
        cyc("t5_after", 0, 1, 0, 0, 32'h10, '0, 0, 0, 0, '0, '0, 1, 0, K0, '0);
        idle("t5_idle");

        // abandoned lock: OWN0 with no m0 request grants nobody for one cycle
        cyc("t7_lock", 0, 1, 0, 1, 32'h10, '0, 0, 0, 0, '0, '0, 1, 0, K0, '0);
        cyc("t7_drop", 0, 0, 0, 0, '0, '0, 1, 0, 0, 32'h208, '0, 0, 0, '0, '0);
        cyc("t7_m1",   0, 0, 0, 0, '0, '0, 1, 0, 0, 32'h208, '0, 0, 1, '0, K2);
        idle("end_idle");

        @(negedge clk);
        #1;
        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
